// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD counter sequencer.
// State enum, digit limits and a digit validity check.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic bcd_is_valid(
    input logic [BCD_W-1:0] digit
  );
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decimal digit of the cascade: clear, load, or wrap-increment.
// Ports: clk, rst, clr, inc, ld, ld_val[3:0] in; q[3:0], at_max out.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       at_max
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      q <= '0;
    else if (ld)
      q <= ld_val;
    else if (inc)
      q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
  end

  assign at_max = (q == BCD_MAX);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Sequencer for a NUM_DIGITS BCD counter: commands, serial preset,
// carry chain and terminal-count compare.
// Ports: clk, rst, start, stop, clear, load_req, preset_valid,
// preset_digit, tick, target_en, target_bcd in; preset_ready,
// count_bcd, running, done, wrap, bad_digit out.
module bcd_count_ctrl
  import bcd_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  localparam int CW         = 4 * NUM_DIGITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          clear,
  input  logic          load_req,
  input  logic          preset_valid,
  input  logic [3:0]    preset_digit,
  output logic          preset_ready,
  input  logic          tick,
  input  logic          target_en,
  input  logic [CW-1:0] target_bcd,
  output logic [CW-1:0] count_bcd,
  output logic          running,
  output logic          done,
  output logic          wrap,
  output logic          bad_digit
);

  localparam logic [3:0] LAST = 4'(NUM_DIGITS - 1);

  state_t state, state_n;
  state_t ret_state, ret_n;
  logic [3:0] load_cnt, cnt_n;
  logic       wrap_q, bad_q;

  logic illegal, clr_all;
  logic accept, count_en, hit, roll;
  logic [3:0] ins;

  logic [NUM_DIGITS-1:0] at_max;
  logic [CW-1:0]         q_bus, nxt_bus;

  assign illegal  = !(state inside {IDLE, LOAD, RUN, HOLD, DONE});
  assign clr_all  = clear | illegal;
  assign accept   = (state == LOAD) & preset_valid & ~clear;
  // stop wins over a same-cycle tick
  assign count_en = (state == RUN) & tick & ~clear & ~stop;
  assign ins      = bcd_is_valid(preset_digit) ? preset_digit : 4'd0;
  assign roll     = &at_max;
  assign hit      = target_en & (nxt_bus == target_bcd);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    logic [3:0] ldv;
    logic       lo9;
    logic       inc;

    if (i == 0) begin : g_lsd
      assign ldv = ins;
      assign lo9 = 1'b1;
    end else begin : g_up
      // preset shifts the bus up one digit per accept
      assign ldv = q_bus[4*(i-1) +: 4];
      assign lo9 = &at_max[i-1:0];
    end

    assign inc = count_en & lo9;

    assign nxt_bus[4*i +: 4] =
      !inc       ? q_bus[4*i +: 4] :
      at_max[i]  ? 4'd0 :
                   q_bus[4*i +: 4] + 4'd1;

    bcd_digit_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr_all),
      .inc    (inc),
      .ld     (accept),
      .ld_val (ldv),
      .q      (q_bus[4*i +: 4]),
      .at_max (at_max[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ret_state <= IDLE;
      load_cnt  <= '0;
      wrap_q    <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state     <= state_n;
      ret_state <= ret_n;
      load_cnt  <= cnt_n;
      wrap_q    <= count_en & roll;
      bad_q     <= accept & ~bcd_is_valid(preset_digit);
    end
  end

  always_comb begin
    state_n = state;
    ret_n   = ret_state;
    cnt_n   = load_cnt;
    if (clr_all) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE, HOLD: begin
          if (!stop && start) begin
            state_n = RUN;
          end else if (!stop && load_req) begin
            state_n = LOAD;
            ret_n   = state;
            cnt_n   = '0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (load_cnt == LAST)
              state_n = ret_state;
            else
              cnt_n = load_cnt + 4'd1;
          end
        end
        RUN: begin
          if (stop)
            state_n = HOLD;
          else if (count_en && hit)
            state_n = DONE;
        end
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    preset_ready = (state == LOAD);
    running      = (state == RUN);
    done         = (state == DONE);
    wrap         = wrap_q;
    bad_digit    = bad_q;
    count_bcd    = q_bus;
  end

endmodule
